// File: rtl/rsf_buf_rd_if.sv
// Port bundle of rsf_buf_rd: start/status, SRAM RSF port, and the output stream.
// RSF_BUF_RD_ABORT_EN adds the i_abort input.
interface rsf_buf_rd_if #(
  parameter int unsigned AW = 12,
  parameter int unsigned DW = 14
) ();
  logic          i_start;
  logic [AW-1:0] i_base_a;
  logic [AW-1:0] i_ofs;
  logic [AW-1:0] i_len;
  logic          o_busy;
  logic          o_done;
  logic          o_data_access;
  logic          o_mem_ck;
  logic          o_mem_csb;
  logic [AW-1:0] o_mem_a;
  logic          o_mem_web;
  logic [DW-1:0] o_mem_di;
  logic [DW-1:0] i_mem_do;
  logic [DW-1:0] o_rd_data;
  logic          o_rd_valid;
  logic          i_rd_ready;
  logic          o_rd_last;
`ifdef RSF_BUF_RD_ABORT_EN
  logic          i_abort;
`endif

  modport master (
`ifdef RSF_BUF_RD_ABORT_EN
    input  i_abort,
`endif
    input  i_start, i_base_a, i_ofs, i_len, i_mem_do, i_rd_ready,
    output o_busy, o_done, o_data_access, o_mem_ck, o_mem_csb, o_mem_a, o_mem_web, o_mem_di,
    output o_rd_data, o_rd_valid, o_rd_last
  );

  modport slave (
`ifdef RSF_BUF_RD_ABORT_EN
    output i_abort,
`endif
    output i_start, i_base_a, i_ofs, i_len, i_mem_do, i_rd_ready,
    input  o_busy, o_done, o_data_access, o_mem_ck, o_mem_csb, o_mem_a, o_mem_web, o_mem_di,
    input  o_rd_data, o_rd_valid, o_rd_last
  );
endinterface

// File: rtl/rsf_buf_rd.sv
// Ring-buffer read master on the sram_ctrl RSF port, streaming words through a 4-entry FIFO.
// Optional abort input enabled by defining RSF_BUF_RD_ABORT_EN.
module rsf_buf_rd #(
  parameter int unsigned AW        = 12,
  parameter int unsigned DW        = 14,
  parameter int unsigned FRAME_LEN = 560
) (
  input logic          i_clk,
  input logic          i_rst,
  rsf_buf_rd_if.master bus
);
  localparam logic [AW-1:0] FrameLen = AW'(FRAME_LEN);
  localparam logic [AW-1:0] PtrMax   = AW'(FRAME_LEN - 1);

  typedef enum logic [2:0] {StIdle, StArm, StRead, StDrain, StDone} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] base_q, ptr_q, len_q, issued_q, popped_q;
  logic          inflight_q;
  logic [DW-1:0] fifo_q [4];
  logic [1:0]    wr_ptr_q, rd_ptr_q;
  logic [2:0]    count_q;
  logic          abort, issue, push, pop, rd_valid, head_last;

  always_comb begin
    abort = 1'b0;
`ifdef RSF_BUF_RD_ABORT_EN
    abort = bus.i_abort & (state_q inside {StArm, StRead, StDrain});
`endif
    rd_valid  = count_q != 3'd0;
    pop       = rd_valid & bus.i_rd_ready;
    head_last = rd_valid & (popped_q == len_q - 1'b1);
    // Reserve a slot for the read still in flight so a stalled consumer never overflows.
    issue     = (state_q == StRead) & (issued_q < len_q) &
                ((count_q + 3'(inflight_q)) < 3'd4) & ~abort;
    push      = inflight_q & ~abort;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.i_start) state_d = (bus.i_len == '0) ? StDone : StArm;
      StArm:   state_d = StRead;
      StRead:  if (issue && (issued_q == len_q - 1'b1)) state_d = StDrain;
      StDrain: if (pop && head_last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (abort) state_d = StDone;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= StIdle;
      base_q     <= '0;
      ptr_q      <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      popped_q   <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      if (state_q == StIdle && bus.i_start) begin
        base_q   <= bus.i_base_a;
        ptr_q    <= bus.i_ofs;
        len_q    <= (bus.i_len > FrameLen) ? FrameLen : bus.i_len;
        issued_q <= '0;
        popped_q <= '0;
      end else begin
        if (issue) begin
          ptr_q    <= (ptr_q == PtrMax) ? '0 : ptr_q + 1'b1;
          issued_q <= issued_q + 1'b1;
        end
        if (pop) popped_q <= popped_q + 1'b1;
      end
      if (abort) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        count_q <= count_q + 3'(push) - 3'(pop);
      end
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge i_clk) begin
    if (push) fifo_q[wr_ptr_q] <= bus.i_mem_do;
  end

  assign bus.o_mem_ck      = i_clk;
  assign bus.o_mem_csb     = ~issue;
  assign bus.o_mem_a       = base_q + ptr_q;
  assign bus.o_mem_web     = 1'b1;
  assign bus.o_mem_di      = '0;
  assign bus.o_rd_data     = fifo_q[rd_ptr_q];
  assign bus.o_rd_valid    = rd_valid;
  assign bus.o_rd_last     = head_last;
  assign bus.o_busy        = state_q != StIdle;
  assign bus.o_done        = state_q == StDone;
  assign bus.o_data_access = state_q inside {StArm, StRead, StDrain};
endmodule

// File: tb/tb_rsf_buf_rd.sv
// Self-checking bench for rsf_buf_rd: directed transfers plus randomized transfers
// with random backpressure, checked against a ring-address/queue reference model.
module tb_rsf_buf_rd;
  localparam int AW        = 12;
  localparam int DW        = 14;
  localparam int FRAME_LEN = 560;
  localparam int BOUND     = 3000;

  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  rsf_buf_rd_if #(.AW(AW), .DW(DW)) bus ();

  rsf_buf_rd #(.AW(AW), .DW(DW), .FRAME_LEN(FRAME_LEN)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // Synchronous-read SRAM: data appears the cycle after a low-csb cycle.
  logic [DW-1:0] mem [4096];
  logic [DW-1:0] mem_do;
  always @(posedge clk) if (bus.o_mem_csb == 1'b0) mem_do <= mem[bus.o_mem_a];
  assign bus.i_mem_do = mem_do;

  int errors = 0;
  int checks = 0;
  int iss_hist [BOUND+1];
  int g_nissue, g_npop, g_done_cyc, g_first_valid, g_last_pop;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic ready_at(input int rmode, input int lo_from, input int lo_to,
                                    input int cyc);
    if (rmode == 1) return !(cyc >= lo_from && cyc <= lo_to);
    if (rmode == 2) return ($urandom % 4) != 0;
    return 1'b1;
  endfunction

  // Cycle 0 is the cycle in which start is sampled; sampling happens on the falling edge.
  task automatic run_xfer(input int base, input int ofs, input int len, input int rmode,
                          input int lo_from, input int lo_to, input int exp_done,
                          input int poke_cyc, input int rst_cyc, input int abort_cyc);
    int eff;
    int exp_a[$];
    int cyc;
    bit fin;
    bit was_rst;
    eff = (len > FRAME_LEN) ? FRAME_LEN : len;
    exp_a.delete();
    for (int i = 0; i < eff; i++) exp_a.push_back((base + (ofs + i) % FRAME_LEN) % 4096);
    g_nissue = 0; g_npop = 0; g_done_cyc = -1; g_first_valid = -1; g_last_pop = -1;
    fin = 0; was_rst = 0; cyc = 0;
    @(posedge clk); #1;
    bus.i_start    = 1'b1;
    bus.i_base_a   = AW'(base);
    bus.i_ofs      = AW'(ofs);
    bus.i_len      = AW'(len);
    bus.i_rd_ready = ready_at(rmode, lo_from, lo_to, cyc);
    while (!fin) begin
`ifdef RSF_BUF_RD_ABORT_EN
      bus.i_abort = (cyc == abort_cyc);
`endif
      if (cyc == rst_cyc) begin
        rst = 1'b1;
        #1;
        check("rst_csb", bus.o_mem_csb, 1);
        check("rst_access", bus.o_data_access, 0);
        check("rst_valid", bus.o_rd_valid, 0);
        check("rst_busy", bus.o_busy, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("rst_no_done", bus.o_done, 0);
        end
        fin = 1; was_rst = 1;
      end else begin
        @(negedge clk);
        check("web", bus.o_mem_web, 1);
        if (cyc == 0) check("busy_c0", bus.o_busy, 0);
        if (bus.o_mem_csb == 1'b0) begin
          if (g_nissue < eff) check("addr", bus.o_mem_a, exp_a[g_nissue]);
          else check("extra_issue", g_nissue, eff);
          g_nissue++;
        end
        check("occupancy", (g_nissue - g_npop) <= 4, 1);
        if (bus.o_rd_valid && g_first_valid < 0) g_first_valid = cyc;
        if (bus.o_rd_valid && bus.i_rd_ready) begin
          if (g_npop < eff) begin
            check("data", bus.o_rd_data, mem[exp_a[g_npop]]);
            check("last", bus.o_rd_last, g_npop == eff - 1);
          end else check("extra_pop", g_npop, eff);
          g_npop++;
          g_last_pop = cyc;
        end
        iss_hist[cyc] = g_nissue;
        if (bus.o_done) begin
          g_done_cyc = cyc;
          check("done_access", bus.o_data_access, 0);
          check("done_valid", bus.o_rd_valid, 0);
          check("done_busy", bus.o_busy, 1);
          fin = 1;
        end else if (cyc >= 1) check("access", bus.o_data_access, 1);
        if (!fin && cyc >= BOUND) begin
          check("done_seen", bus.o_done, 1);
          fin = 1;
        end
        if (!fin) begin
          @(posedge clk); #1;
          cyc++;
          bus.i_start = (cyc == poke_cyc);
          if (cyc == poke_cyc) begin
            bus.i_base_a = '0;
            bus.i_ofs    = '0;
            bus.i_len    = AW'(3);
          end
          bus.i_rd_ready = ready_at(rmode, lo_from, lo_to, cyc);
        end
      end
    end
    bus.i_start = 1'b0;
`ifdef RSF_BUF_RD_ABORT_EN
    bus.i_abort = 1'b0;
`endif
    if (!was_rst) begin
      @(posedge clk); #1;
      bus.i_rd_ready = 1'b1;
      @(negedge clk);
      check("busy_after", bus.o_busy, 0);
      check("done_pulse", bus.o_done, 0);
      if (abort_cyc < 0) begin
        check("n_issue", g_nissue, eff);
        check("n_pop", g_npop, eff);
      end else begin
        check("abort_done_cyc", g_done_cyc, abort_cyc + 1);
        check("abort_no_issue", g_nissue, iss_hist[abort_cyc-1]);
      end
      if (exp_done >= 0) begin
        check("done_cyc", g_done_cyc, exp_done);
        if (eff > 0) begin
          check("first_valid", g_first_valid, 4);
          check("last_pop", g_last_pop, eff + 3);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = DW'(i);
    rst = 1'b1;
    bus.i_start = 1'b0; bus.i_base_a = '0; bus.i_ofs = '0; bus.i_len = '0;
    bus.i_rd_ready = 1'b1;
`ifdef RSF_BUF_RD_ABORT_EN
    bus.i_abort = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_csb", bus.o_mem_csb, 1);
    check("reset_access", bus.o_data_access, 0);
    check("reset_busy", bus.o_busy, 0);
    check("reset_done", bus.o_done, 0);
    check("reset_valid", bus.o_rd_valid, 0);
    check("reset_last", bus.o_rd_last, 0);
    check("reset_addr", bus.o_mem_a, 0);
    @(posedge clk); #1 rst = 1'b0;

    // base, ofs, len, rmode, lo_from, lo_to, exp_done, poke, rst, abort
    run_xfer(560, 0, 8, 0, 0, 0, 12, -1, -1, -1);
    run_xfer(1120, 556, 6, 0, 0, 0, 10, -1, -1, -1);
    run_xfer(0, 100, 10, 1, 2, 9, -1, -1, -1, -1);
    check("bp_issued_c5", iss_hist[5], 4);
    check("bp_issued_c9", iss_hist[9], 4);
    run_xfer(5, 3, 0, 0, 0, 0, 1, -1, -1, -1);
    run_xfer(3700, 10, 700, 0, 0, 0, 564, -1, -1, -1);
    run_xfer(200, 50, 12, 0, 0, 0, 16, 5, -1, -1);
    run_xfer(40, 20, 20, 0, 0, 0, -1, -1, 6, -1);
    run_xfer(7, 0, 5, 0, 0, 0, 9, -1, -1, -1);
`ifdef RSF_BUF_RD_ABORT_EN
    run_xfer(900, 30, 20, 0, 0, 0, -1, -1, -1, 5);
    run_xfer(11, 2, 4, 0, 0, 0, 8, -1, -1, -1);
`endif
    for (int t = 0; t < 8; t++) begin
      int b, o, l;
      b = $urandom_range(0, 4095);
      o = $urandom_range(0, FRAME_LEN - 1);
      l = (t == 7) ? $urandom_range(561, 4095) : $urandom_range(0, 40);
      run_xfer(b, o, l, 2, 0, 0, -1, -1, -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
